pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush scheduler for the 5-stage pipeline. It gathers every reason the pipeline may not advance: load-use hazard from ID, jump from ID, taken branch resolved in EX/MEM, and a variable-latency data-memory handshake. It turns them into one prioritised set of per-stage write-enable and flush strobes. It also flags a hung data memory and keeps saturating stall and flush performance counters.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `MEM_TIMEOUT`, default 16: wait cycles in MEM_WAIT (≥2) before a timeout is declared.

- `clk` in 1: the single clock.
- `rst` in 1: reset; synchronous, active-high.
- `load_use_hazard` in 1: raw hazard detect from ID (load in ID/EX targets rs1/rs2 in IF/ID).
- `jump_id` in 1: jump decoded in ID.
- `branch_taken_mem` in 1: taken branch resolved in EX/MEM.
- `dmem_access` in 1: EX/MEM holds a valid memread or memwrite.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_write` out 1: PC register load enable.
- `if_id_write` out 1: IF/ID load enable.
- `if_id_flush` out 1: IF/ID cleared to NOP.
- `id_ex_flush` out 1: ID/EX control fields zeroed (bubble).
- `ex_mem_write` out 1: ID/EX and EX/MEM load enable.
- `ex_mem_flush` out 1: EX/MEM control fields zeroed.
- `mem_wb_bubble` out 1: MEM/WB loads a bubble.
- `mem_timeout` out 1: sticky error flag.
- `stall_count` out CNT_W: cycles with pc_write=0, excluding reset and TIMEOUT.
- `flush_count` out CNT_W: cycles with if_id_flush=1.
- `ctrl_state` out 2: FSM state, for debug.

## Operation
- FSM states: RUN=0, MEM_WAIT=1, TIMEOUT=2. Outputs are Mealy (state + inputs, same cycle); state and counters are registered.
- **Reset.** While rst=1, all strobes are 0, mem_timeout=0, both counters 0 and state=RUN. The next state after rst deasserts is RUN.
- **RUN priority, highest first:**
  1. dmem_access && !dmem_ready. Freeze: pc_write=0, if_id_write=0, ex_mem_write=0, mem_wb_bubble=1, all flushes 0. Wait counter loads 1. Next state MEM_WAIT.
  2. branch_taken_mem. pc_write=1, if_id_write=1, ex_mem_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1. Jump and hazard are ignored.
  3. jump_id. pc_write=1, if_id_write=1, ex_mem_write=1, if_id_flush=1.
  4. load_use_hazard. pc_write=0, if_id_write=0, ex_mem_write=1, id_ex_flush=1.
  5. Otherwise all writes are 1 and no flushes.
- **MEM_WAIT, dmem_ready=0.** Freeze as in RUN row 1; wait counter increments. When the counter reaches MEM_TIMEOUT, next state is TIMEOUT.
- **MEM_WAIT, dmem_ready=1.** The access completes. Outputs follow RUN rows 2–5, evaluated on the current inputs. Next state RUN.
- **TIMEOUT.** All writes 0, mem_timeout=1, counters frozen. The only exit is rst.
- **Counters.** Increment as defined in Interface and saturate at 2^CNT_W−1; they never wrap.

## Timing
- Strobes are combinational from inputs with zero latency. Exactly one priority row is active per cycle.
- A zero-wait access (dmem_access && dmem_ready in RUN) adds no stall cycle.
- A memory access that is ready after N wait cycles freezes the pipeline for exactly N cycles. Writes resume in the ready cycle.
- MEM_WAIT entered on cycle t with dmem_ready never asserted: cycles t..t+MEM_TIMEOUT−1 are frozen, ctrl_state=2 from cycle t+MEM_TIMEOUT.
- Branch or hazard asserted during a memory freeze has no effect until the ready cycle. At that cycle it is evaluated normally, since EX/MEM is held.
- rst asserted in any state, including mid-MEM_WAIT, takes effect at the next edge: state RUN, counters 0, mem_timeout cleared.

## Structure
- Shared package/header `pipeline_ctrl_pkg` holds the state encodings (RUN, MEM_WAIT, TIMEOUT) and the default MEM_TIMEOUT.
- Sub-module `sat_counter` (parameter W; ports clk, rst, inc, count) is instantiated twice, for stall_count and flush_count.
- The wait counter is internal, $clog2(MEM_TIMEOUT+1) bits wide.

## Test plan
- **Load-use:** load_use_hazard=1 for 1 cycle in RUN → pc_write=0, if_id_write=0, id_ex_flush=1; stall_count 0→1; next cycle all writes 1.
- **Branch over others:** branch_taken_mem=1 with jump_id=1 and load_use_hazard=1 → all three flushes 1, pc_write=1; flush_count +1; stall_count unchanged.
- **Memory wait:** dmem_access=1, dmem_ready asserted on the 4th cycle → 3 frozen cycles with mem_wb_bubble=1 and ctrl_state=1; ready cycle all writes 1; stall_count=3.
- **Timeout:** MEM_TIMEOUT=16, dmem_access=1, dmem_ready held 0 → ctrl_state=2 at cycle 16 and mem_timeout=1, sticky for 10 more cycles; rst → all outputs 0, state RUN.
- **Reset mid-wait:** rst pulsed on the 2nd wait cycle → next cycle ctrl_state=0, stall_count=0, and with dmem_access=0 all writes 1.
- **Saturation:** CNT_W=4, 20 consecutive load-use cycles → stall_count holds at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush scheduler: FSM encodings,
// the per-stage strobe bundle and the advance-priority resolver.
package pipeline_ctrl_pkg;

    localparam int MEM_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } ctrl_state_e;

    // One bundle of every strobe the scheduler drives into the pipeline.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_write;
        logic ex_mem_flush;
        logic mem_wb_bubble;
    } strobes_t;

    localparam strobes_t STROBES_OFF = '0;

    // Whole pipeline held, MEM/WB takes a bubble while the access is pending.
    localparam strobes_t STROBES_FREEZE = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0,
        ex_mem_write: 1'b0, ex_mem_flush: 1'b0, mem_wb_bubble: 1'b1
    };

    // Priority among the reasons that apply once memory is not blocking:
    // taken branch > jump > load-use > free-running.
    function automatic strobes_t resolve_advance(input logic branch_taken,
                                                 input logic jump,
                                                 input logic load_use);
        strobes_t s;
        s = '{
            pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
            ex_mem_write: 1'b1, ex_mem_flush: 1'b0, mem_wb_bubble: 1'b0
        };
        if (branch_taken) begin
            // Wrong-path instructions live in IF/ID, ID/EX and EX/MEM.
            s.if_id_flush  = 1'b1;
            s.id_ex_flush  = 1'b1;
            s.ex_mem_flush = 1'b1;
        end else if (jump) begin
            s.if_id_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, let the load move on and insert a bubble behind it.
            s.pc_write    = 1'b0;
            s.if_id_write = 1'b0;
            s.id_ex_flush = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && !(&count_q)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler: prioritises memory wait, branch, jump and
// load-use into per-stage write/flush strobes, detects a hung data memory,
// and keeps saturating stall/flush counters.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_hazard,
    input  logic             jump_id,
    input  logic             branch_taken_mem,
    input  logic             dmem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             ex_mem_flush,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       ctrl_state
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e     state_q, state_d;
    logic [WC_W-1:0] wait_q, wait_d;
    strobes_t        strb;
    logic            timeout_flag;
    logic            stall_inc;
    logic            flush_inc;

    // State and wait-cycle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state and Mealy strobes; reset forces every strobe low.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        strb         = STROBES_OFF;
        timeout_flag = 1'b0;
        case (state_q)
            RUN: begin
                if (dmem_access && !dmem_ready) begin
                    strb    = STROBES_FREEZE;
                    wait_d  = WC_W'(1);
                    state_d = MEM_WAIT;
                end else begin
                    strb = resolve_advance(branch_taken_mem, jump_id, load_use_hazard);
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    strb   = STROBES_FREEZE;
                    wait_d = wait_q + WC_W'(1);
                    // wait_q counts frozen cycles already spent; this one makes MEM_TIMEOUT.
                    if (wait_q >= WC_W'(MEM_TIMEOUT - 1)) begin
                        state_d = TIMEOUT;
                    end
                end else begin
                    // EX/MEM was held, so the pending branch/hazard is still current.
                    strb    = resolve_advance(branch_taken_mem, jump_id, load_use_hazard);
                    state_d = RUN;
                end
            end
            TIMEOUT: begin
                timeout_flag = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (rst) begin
            strb         = STROBES_OFF;
            timeout_flag = 1'b0;
        end
    end

    // Stalls are PC-hold cycles; a hung memory is reported by the flag, not the counter.
    assign stall_inc = !rst && (state_q != TIMEOUT) && !strb.pc_write;
    assign flush_inc = strb.if_id_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_count)
    );

    assign pc_write      = strb.pc_write;
    assign if_id_write   = strb.if_id_write;
    assign if_id_flush   = strb.if_id_flush;
    assign id_ex_flush   = strb.id_ex_flush;
    assign ex_mem_write  = strb.ex_mem_write;
    assign ex_mem_flush  = strb.ex_mem_flush;
    assign mem_wb_bubble = strb.mem_wb_bubble;
    assign mem_timeout   = timeout_flag;
    assign ctrl_state    = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (CNT_W=4 so saturation is reachable).
module tb_pipeline_stall_ctrl;

    logic       clk, rst;
    logic       load_use_hazard, jump_id, branch_taken_mem, dmem_access, dmem_ready;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic       ex_mem_write, ex_mem_flush, mem_wb_bubble, mem_timeout;
    logic [3:0] stall_count, flush_count;
    logic [1:0] ctrl_state;

    int n_tests = 0;
    int n_fail  = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_bubble}
    wire [6:0] strb = {pc_write, if_id_write, if_id_flush, id_ex_flush,
                       ex_mem_write, ex_mem_flush, mem_wb_bubble};

    localparam logic [6:0] S_OFF    = 7'b0000000;
    localparam logic [6:0] S_NORM   = 7'b1100100;
    localparam logic [6:0] S_FREEZE = 7'b0000001;
    localparam logic [6:0] S_LOADU  = 7'b0001100;
    localparam logic [6:0] S_BRANCH = 7'b1111110;
    localparam logic [6:0] S_JUMP   = 7'b1110100;

    pipeline_stall_ctrl #(.CNT_W(4), .MEM_TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .load_use_hazard  (load_use_hazard),
        .jump_id          (jump_id),
        .branch_taken_mem (branch_taken_mem),
        .dmem_access      (dmem_access),
        .dmem_ready       (dmem_ready),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_write     (ex_mem_write),
        .ex_mem_flush     (ex_mem_flush),
        .mem_wb_bubble    (mem_wb_bubble),
        .mem_timeout      (mem_timeout),
        .stall_count      (stall_count),
        .flush_count      (flush_count),
        .ctrl_state       (ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic lu, input logic jmp, input logic br,
                          input logic acc, input logic rdy);
        load_use_hazard  = lu;
        jump_id          = jmp;
        branch_taken_mem = br;
        dmem_access      = acc;
        dmem_ready       = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 1, 1, 1, 0);
        tick();
        #1;
        n_tests++;
        if (strb !== S_OFF) begin n_fail++; $display("FAIL reset_strobes: got %b want %b", strb, S_OFF); end
        n_tests++;
        if ({mem_timeout, ctrl_state, stall_count, flush_count} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got to=%b st=%0d sc=%0d fc=%0d want all 0",
                     mem_timeout, ctrl_state, stall_count, flush_count);
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (strb !== S_NORM) begin n_fail++; $display("FAIL reset_release: got %b want %b", strb, S_NORM); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (strb !== S_LOADU) begin n_fail++; $display("FAIL load_use_strobes: got %b want %b", strb, S_LOADU); end
        n_tests++;
        if (stall_count !== 4'd0) begin n_fail++; $display("FAIL load_use_cnt0: got %0d want 0", stall_count); end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (stall_count !== 4'd1) begin n_fail++; $display("FAIL load_use_cnt1: got %0d want 1", stall_count); end
        n_tests++;
        if (strb !== S_NORM) begin n_fail++; $display("FAIL load_use_after: got %b want %b", strb, S_NORM); end
        tick();
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_in(1, 1, 1, 0, 0);
        #1;
        n_tests++;
        if (strb !== S_BRANCH) begin n_fail++; $display("FAIL branch_strobes: got %b want %b", strb, S_BRANCH); end
        tick();
        set_in(1, 1, 0, 0, 0);
        #1;
        n_tests++;
        if (strb !== S_JUMP) begin n_fail++; $display("FAIL jump_strobes: got %b want %b", strb, S_JUMP); end
        n_tests++;
        if ({flush_count, stall_count} !== {4'd1, 4'd0}) begin
            n_fail++; $display("FAIL branch_counts: got fc=%0d sc=%0d want fc=1 sc=0", flush_count, stall_count);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if ({flush_count, stall_count} !== {4'd2, 4'd0}) begin
            n_fail++; $display("FAIL jump_counts: got fc=%0d sc=%0d want fc=2 sc=0", flush_count, stall_count);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_in(0, 0, 0, 1, 0);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) branch_taken_mem = 1'b1;  // must be ignored while frozen
            #1;
            n_tests++;
            if (strb !== S_FREEZE || ctrl_state !== ((c == 1) ? 2'd0 : 2'd1)) begin
                n_fail++;
                $display("FAIL mem_wait_freeze_c%0d: got %b st=%0d want %b st=%0d",
                         c, strb, ctrl_state, S_FREEZE, (c == 1) ? 0 : 1);
            end
            tick();
        end
        set_in(0, 0, 0, 1, 1);
        #1;
        n_tests++;
        if (strb !== S_NORM || ctrl_state !== 2'd1) begin
            n_fail++; $display("FAIL mem_wait_ready: got %b st=%0d want %b st=1", strb, ctrl_state, S_NORM);
        end
        tick();
        set_in(0, 0, 0, 1, 1);  // zero-wait access in RUN
        #1;
        n_tests++;
        if (strb !== S_NORM || ctrl_state !== 2'd0 || stall_count !== 4'd3 || flush_count !== 4'd0) begin
            n_fail++;
            $display("FAIL mem_wait_after: got %b st=%0d sc=%0d fc=%0d want %b st=0 sc=3 fc=0",
                     strb, ctrl_state, stall_count, flush_count, S_NORM);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (stall_count !== 4'd3) begin n_fail++; $display("FAIL zero_wait_cnt: got %0d want 3", stall_count); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        set_in(0, 0, 0, 1, 0);
        for (int c = 0; c < 16; c++) begin
            #1;
            n_tests++;
            if (strb !== S_FREEZE || ctrl_state !== ((c == 0) ? 2'd0 : 2'd1) || mem_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait_c%0d: got %b st=%0d to=%b", c, strb, ctrl_state, mem_timeout);
            end
            tick();
        end
        #1;
        n_tests++;
        if (ctrl_state !== 2'd2 || mem_timeout !== 1'b1 || strb !== S_OFF || stall_count !== 4'd15) begin
            n_fail++;
            $display("FAIL timeout_enter: got st=%0d to=%b %b sc=%0d want st=2 to=1 %b sc=15",
                     ctrl_state, mem_timeout, strb, stall_count, S_OFF);
        end
        set_in(1, 1, 1, 0, 1);  // nothing but reset may leave TIMEOUT
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if (ctrl_state !== 2'd2 || mem_timeout !== 1'b1 || strb !== S_OFF || flush_count !== 4'd0) begin
                n_fail++;
                $display("FAIL timeout_sticky_c%0d: got st=%0d to=%b %b fc=%0d", c, ctrl_state, mem_timeout, strb, flush_count);
            end
        end
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (strb !== S_OFF || mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_rst_comb: got %b to=%b want %b to=0", strb, mem_timeout, S_OFF);
        end
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (ctrl_state !== 2'd0 || mem_timeout !== 1'b0 || stall_count !== 4'd0 || strb !== S_NORM) begin
            n_fail++;
            $display("FAIL timeout_rst: got st=%0d to=%b sc=%0d %b", ctrl_state, mem_timeout, stall_count, strb);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_in(0, 0, 0, 1, 0);
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if (strb !== S_OFF || ctrl_state !== 2'd1 || stall_count !== 4'd1) begin
            n_fail++; $display("FAIL midwait_rst: got %b st=%0d sc=%0d want %b st=1 sc=1", strb, ctrl_state, stall_count, S_OFF);
        end
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (ctrl_state !== 2'd0 || stall_count !== 4'd0 || strb !== S_NORM) begin
            n_fail++; $display("FAIL midwait_after: got st=%0d sc=%0d %b want st=0 sc=0 %b", ctrl_state, stall_count, strb, S_NORM);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(1, 0, 0, 0, 0);
        for (int c = 0; c < 20; c++) tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (stall_count !== 4'd15) begin n_fail++; $display("FAIL saturation: got %0d want 15", stall_count); end
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (stall_count !== 4'd15) begin n_fail++; $display("FAIL saturation_hold: got %0d want 15", stall_count); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        // One wait cycle, then ready with a load-use hazard pending.
        set_in(0, 0, 0, 1, 0);
        tick();
        set_in(1, 0, 0, 1, 1);
        #1;
        n_tests++;
        if (strb !== S_LOADU || ctrl_state !== 2'd1) begin
            n_fail++; $display("FAIL b2b_ready_hazard: got %b st=%0d want %b st=1", strb, ctrl_state, S_LOADU);
        end
        tick();
        set_in(0, 1, 0, 0, 0);
        #1;
        n_tests++;
        if (strb !== S_JUMP || ctrl_state !== 2'd0) begin
            n_fail++; $display("FAIL b2b_jump: got %b st=%0d want %b st=0", strb, ctrl_state, S_JUMP);
        end
        tick();
        set_in(0, 0, 1, 0, 0);
        #1;
        n_tests++;
        if (strb !== S_BRANCH) begin n_fail++; $display("FAIL b2b_branch: got %b want %b", strb, S_BRANCH); end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if ({stall_count, flush_count} !== {4'd2, 4'd2}) begin
            n_fail++; $display("FAIL b2b_counts: got sc=%0d fc=%0d want sc=2 fc=2", stall_count, flush_count);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
